button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Parametrised, multi-channel successor to the single-button synchroniser/one-shot.
- Per channel, in order:
  - synchronises a raw pushbutton;
  - debounces it with a stable-count filter;
  - emits one-cycle Press and Release pulses;
  - optionally emits auto-repeat Press pulses while the button is held.
- Sits between board pushbuttons and processor/front-panel control logic, replacing per-button one-shot instances.

Parameters:
- NUM_BTN, 4: number of independent channels (>=1).
- SYNC_STAGES, 2: flip-flop synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a level change (>=1).
- REPEAT_DELAY, 25_000_000: cycles from the accepted press to the first repeat pulse (>=1).
- REPEAT_RATE, 5_000_000: cycles between subsequent repeat pulses (>=1).
- ACTIVE_LOW, 0: 1 inverts raw inputs before synchronisation (pressed = 0 on pin).

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- Bis  in  NUM_BTN  raw, unregistered button inputs (asynchronous to Clk).
- RepeatEn  in  NUM_BTN  per-channel auto-repeat enable (synchronous to Clk).
- Level  out  NUM_BTN  debounced pressed level (1 = pressed).
- Press  out  NUM_BTN  one-cycle pulse on accepted press and on each repeat.
- Release  out  NUM_BTN  one-cycle pulse on accepted release.

Behaviour:
- Clocking and reset:
  - One clock, Clk. Reset is synchronous and active-high, sampled on posedge Clk.
  - On reset: all sync stages, Level, Press, Release, counters = 0; every FSM = IDLE.
- Polarity: ACTIVE_LOW inversion is applied ahead of stage 1, so 0 is always the inactive value.
- Synchroniser:
  - Bis[i] passes through SYNC_STAGES flops to give Bsync[i].
  - Synchroniser flops drive nothing else.
- Debounce:
  - Counter dcnt increments each cycle Bsync != Level and clears whenever they are equal.
  - When dcnt == DEBOUNCE_CYCLES-1 and the mismatch persists, Level toggles at that edge and dcnt clears.
- Latency: Level changes on edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new Bis value.
- Glitches: any mismatch shorter than DEBOUNCE_CYCLES produces no output activity.
- All outputs are registered. Press and Release are high for exactly one cycle.
- Per-channel FSM:
  - IDLE (Level=0)
    - Accepted press: Level<=1, Press<=1, rcnt<=0, go to DELAY.
  - DELAY (Level=1)
    - Accepted release: Level<=0, Release<=1, go to IDLE.
    - Else if RepeatEn and rcnt == REPEAT_DELAY-1: Press<=1, rcnt<=0, go to REPT.
    - Else if RepeatEn: rcnt++.
    - Else: rcnt<=0.
  - REPT (Level=1)
    - Accepted release: Level<=0, Release<=1, go to IDLE.
    - Else if !RepeatEn: rcnt<=0, go to DELAY.
    - Else if rcnt == REPEAT_RATE-1: Press<=1, rcnt<=0.
    - Else: rcnt++.
- Priority: release has priority over a repeat pulse due on the same cycle. Press and Release are never high together.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Reset mid-hold:
  - Outputs go to 0 the cycle after Reset is sampled; no Release pulse is issued.
  - A still-held button is re-synchronised and re-debounced, then issues a fresh Press.
- Counter widths: $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)+1). The counters never overflow.

Decomposition:
- Package btn_pkg holds:
  - typedef enum logic [1:0] btn_state_t {BTN_IDLE, BTN_DELAY, BTN_REPT};
  - a constant function for counter width.
- Sub-module btn_channel (one synchroniser + debounce + FSM), instantiated NUM_BTN times in a generate loop.
- The top level handles only ACTIVE_LOW inversion and bus concatenation.

Test Plan:
- Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, NUM_BTN=4.
- Clean press, RepeatEn=0: Bis[0] 0->1, held 20 cycles, then 0 -> Level[0] rises on the 6th edge with one Press pulse and no repeats; on release, Level falls on the 6th edge with one Release pulse.
- Bounce: Bis[1] toggles every 2 cycles for 12 cycles, then stays 1 -> Level/Press stay 0 during bounce; Level rises on the 6th edge after the final rise. A 3-cycle glitch yields no pulse.
- Auto-repeat: RepeatEn[2]=1, Level held 30 cycles (t0 = Level rise) -> Press at t0, t0+10, 13, 16, 19, 22, 25, 28 (8 pulses); single Release on drop.
- RepeatEn drop: deassert during REPT -> pulses stop. Re-assert -> next Press exactly 10 cycles later, then every 3.
- Independence and simultaneity: press channels 0 and 3 on the same edge (ch3 bouncing 2 cycles first) -> ch0 Press at edge 6, ch3 after its stable window; other channels stay quiet.
- Reset mid-hold: 1-cycle Reset while ch2 is in REPT, button held -> all outputs 0 next cycle, no Release; Press reissued 6 edges after Reset deasserts.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the button conditioner.
// Holds the channel FSM encoding and the counter sizing rule.
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_DELAY,
    BTN_REPT
  } btn_state_t;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, stable-count debounce,
// and press / release / auto-repeat pulse FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Bin,
  input  logic RepeatEn,
  output logic Level,
  output logic Press,
  output logic Release
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES,
                                REPEAT_DELAY,
                                REPEAT_RATE);

  localparam logic [CW-1:0] D_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   bsync;
  logic [CW-1:0]          dcnt;
  logic [CW-1:0]          rcnt;
  logic                   mismatch;
  logic                   accept;
  btn_state_t             state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], Bin};
    end
  end

  assign bsync    = sync[SYNC_STAGES-1];
  assign mismatch = bsync ^ Level;
  assign accept   = mismatch && (dcnt == D_LAST);

  // Release wins over a repeat pulse due on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= BTN_IDLE;
      Level   <= 1'b0;
      Press   <= 1'b0;
      Release <= 1'b0;
      dcnt    <= '0;
      rcnt    <= '0;
    end else begin
      Press   <= 1'b0;
      Release <= 1'b0;
      if (!mismatch || accept) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      unique case (state)
        BTN_IDLE: begin
          if (accept) begin
            Level <= 1'b1;
            Press <= 1'b1;
            rcnt  <= '0;
            state <= BTN_DELAY;
          end
        end
        BTN_DELAY: begin
          if (accept) begin
            Level   <= 1'b0;
            Release <= 1'b1;
            rcnt    <= '0;
            state   <= BTN_IDLE;
          end else if (RepeatEn && rcnt == RD_LAST) begin
            Press <= 1'b1;
            rcnt  <= '0;
            state <= BTN_REPT;
          end else if (RepeatEn) begin
            rcnt <= rcnt + 1'b1;
          end else begin
            rcnt <= '0;
          end
        end
        BTN_REPT: begin
          if (accept) begin
            Level   <= 1'b0;
            Release <= 1'b1;
            rcnt    <= '0;
            state   <= BTN_IDLE;
          end else if (!RepeatEn) begin
            rcnt  <= '0;
            state <= BTN_DELAY;
          end else if (rcnt == RR_LAST) begin
            Press <= 1'b1;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: begin
          state <= BTN_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel pushbutton conditioner: polarity fix-up
// and one independent btn_channel per button.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] Bis,
  input  logic [NUM_BTN-1:0] RepeatEn,
  output logic [NUM_BTN-1:0] Level,
  output logic [NUM_BTN-1:0] Press,
  output logic [NUM_BTN-1:0] Release
);

  logic [NUM_BTN-1:0] bin;

  assign bin = (ACTIVE_LOW != 0) ? ~Bis : Bis;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .Clk     (Clk),
      .Reset   (Reset),
      .Bin     (bin[i]),
      .RepeatEn(RepeatEn[i]),
      .Level   (Level[i]),
      .Press   (Press[i]),
      .Release (Release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random
// stimulus, checked every cycle against a sample-window model.
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [N-1:0] Bis = '0;
  logic [N-1:0] RepeatEn = '0;
  logic [N-1:0] Level;
  logic [N-1:0] Press;
  logic [N-1:0] Release;

  always #5 Clk = ~Clk;

  button_conditioner #(
    .NUM_BTN        (N),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .ACTIVE_LOW     (0)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Bis     (Bis),
    .RepeatEn(RepeatEn),
    .Level   (Level),
    .Press   (Press),
    .Release (Release)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: per-channel history of sampled inputs; a level change is
  // accepted when the D samples seen through the synchroniser all differ.
  logic [S+D-1:0] hist [N];
  logic [N-1:0]   m_lvl;
  logic [N-1:0]   m_prs;
  logic [N-1:0]   m_rel;
  int             run  [N];
  bit             rep  [N];

  task automatic model_edge();
    logic [D-1:0] win;
    bit           flip;
    for (int c = 0; c < N; c++) begin
      m_prs[c] = 1'b0;
      m_rel[c] = 1'b0;
      if (Reset) begin
        hist[c]  = '0;
        m_lvl[c] = 1'b0;
        run[c]   = 0;
        rep[c]   = 1'b0;
      end else begin
        hist[c] = {hist[c][S+D-2:0], Bis[c]};
        win     = hist[c][S+D-1:S];
        flip    = m_lvl[c] ? (win == '0) : (&win);
        if (flip && !m_lvl[c]) begin
          m_lvl[c] = 1'b1;
          m_prs[c] = 1'b1;
          run[c]   = 0;
          rep[c]   = 1'b0;
        end else if (flip) begin
          m_lvl[c] = 1'b0;
          m_rel[c] = 1'b1;
        end else if (m_lvl[c]) begin
          if (RepeatEn[c]) begin
            run[c]++;
            if (run[c] == (rep[c] ? RR : RD)) begin
              m_prs[c] = 1'b1;
              run[c]   = 0;
              rep[c]   = 1'b1;
            end
          end else begin
            run[c] = 0;
            rep[c] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    vectors++;
    assert (Level === m_lvl) else begin
      miscompares++;
      $error("FAIL level: got %b expected %b", Level, m_lvl);
    end
    vectors++;
    assert (Press === m_prs) else begin
      miscompares++;
      $error("FAIL press: got %b expected %b", Press, m_prs);
    end
    vectors++;
    assert (Release === m_rel) else begin
      miscompares++;
      $error("FAIL release: got %b expected %b", Release, m_rel);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int rise;
    int rise3;
    int fall;
    int np;
    int nr;
    int p1;
    int p2;

    for (int c = 0; c < N; c++) begin
      hist[c] = '0;
      run[c]  = 0;
      rep[c]  = 1'b0;
    end
    m_lvl = '0;
    m_prs = '0;
    m_rel = '0;

    Reset = 1'b1;
    ticks(2);
    Reset = 1'b0;
    ticks(3);

    // Clean press and release on channel 0, no repeat.
    Bis[0] = 1'b1;
    rise = 0;
    np = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (Level[0] && rise == 0) rise = k;
      np += int'(Press[0]);
    end
    chk("clean_rise_edge", rise, 6);
    chk("clean_press_count", np, 1);
    Bis[0] = 1'b0;
    fall = 0;
    nr = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!Level[0] && fall == 0) fall = k;
      nr += int'(Release[0]);
    end
    chk("clean_fall_edge", fall, 6);
    chk("clean_release_count", nr, 1);

    // Bounce on channel 1, then settle high.
    np = 0;
    for (int k = 0; k < 12; k++) begin
      Bis[1] = ((k >> 1) & 1) == 0;
      tick();
      np += int'(Press[1]) + int'(Level[1]);
    end
    chk("bounce_quiet", np, 0);
    Bis[1] = 1'b1;
    rise = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (Level[1] && rise == 0) rise = k;
    end
    chk("bounce_rise_edge", rise, 6);
    Bis[1] = 1'b0;
    ticks(10);
    Bis[1] = 1'b1;
    np = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      np += int'(Press[1]) + int'(Level[1]);
    end
    Bis[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      np += int'(Press[1]) + int'(Level[1]);
    end
    chk("glitch_quiet", np, 0);

    // Auto-repeat on channel 2, Level held for 30 cycles.
    RepeatEn[2] = 1'b1;
    Bis[2] = 1'b1;
    np = 0;
    nr = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      np += int'(Press[2]);
    end
    Bis[2] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      np += int'(Press[2]);
      nr += int'(Release[2]);
    end
    chk("repeat_press_count", np, 8);
    chk("repeat_release_count", nr, 1);

    // RepeatEn drop during repeat, then re-assert.
    Bis[2] = 1'b1;
    ticks(20);
    RepeatEn[2] = 1'b0;
    np = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      np += int'(Press[2]);
    end
    chk("repeat_stopped", np, 0);
    RepeatEn[2] = 1'b1;
    p1 = 0;
    p2 = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (Press[2] && p1 == 0) p1 = k;
      else if (Press[2] && p2 == 0) p2 = k;
    end
    chk("reen_first_press", p1, 10);
    chk("reen_second_press", p2, 13);
    Bis[2] = 1'b0;
    RepeatEn[2] = 1'b0;
    ticks(12);

    // Channels 0 and 3 together, channel 3 bouncing first.
    Bis[0] = 1'b1;
    Bis[3] = 1'b1;
    rise = 0;
    rise3 = 0;
    for (int k = 1; k <= 12; k++) begin
      Bis[3] = (k != 2);
      tick();
      if (Level[0] && rise == 0) rise = k;
      if (Level[3] && rise3 == 0) rise3 = k;
    end
    chk("simul_ch0_rise", rise, 6);
    chk("simul_ch3_rise", rise3, 8);
    Bis[0] = 1'b0;
    Bis[3] = 1'b0;
    ticks(10);

    // Reset while channel 2 is auto-repeating.
    Bis[2] = 1'b1;
    RepeatEn[2] = 1'b1;
    ticks(20);
    Reset = 1'b1;
    tick();
    chk("reset_outputs_zero", int'({Level, Press, Release}), 0);
    Reset = 1'b0;
    p1 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (Press[2] && p1 == 0) p1 = k;
    end
    chk("reset_repress_edge", p1, 6);
    Bis[2] = 1'b0;
    RepeatEn[2] = 1'b0;
    ticks(10);

    // Random activity on all channels.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) Bis[c] = ~Bis[c];
        if ($urandom_range(0, 39) == 0) RepeatEn[c] = ~RepeatEn[c];
      end
      Reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    Reset = 1'b0;
    Bis = '0;
    ticks(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
